// File: rtl/boron_enc_scheduler.sv
// Purpose: round-robin scheduler sharing one BORON encryption core between two requesters.
// Latency: job accepted at edge E0 -> LOAD cycle 1, START cycle 2, WAIT until done/timeout, rsp_valid the cycle after.
// Backpressure: one job in flight; req*_ready stays low outside IDLE and RESP holds until the owner's rsp_ready.
//
// Ports:
//   clk, reset                    - system clock (shared with the core), synchronous active-high reset
//   req{0,1}_valid/_ready         - job request handshake; ready is combinational in IDLE only
//   req{0,1}_plain/_key           - 64-bit plaintext, 80-bit master key
//   rsp{0,1}_valid/_ready         - result handshake; only the owner's rsp_valid ever rises
//   rsp{0,1}_cipher/_err          - ciphertext (zero on timeout), timeout flag
//   core_reset                    - core reset, doubling as the core's operand load strobe
//   core_plain_text/_master_key   - operands, stable from LOAD until the return to IDLE
//   core_enc_start, core_enc_done - core start strobe and done pulse
//   core_cipher_text              - core result, sampled only in WAIT when done is high
//   busy                          - high whenever the scheduler is not in IDLE
module boron_enc_scheduler #(
    // Maximum WAIT cycles without done before aborting; legal range 1..63 (6-bit counter).
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_plain,
    input  logic [79:0] req0_key,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_cipher,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_plain,
    input  logic [79:0] req1_key,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_cipher,
    output logic        rsp1_err,
    output logic        core_reset,
    output logic [63:0] core_plain_text,
    output logic [79:0] core_master_key,
    output logic        core_enc_start,
    input  logic [63:0] core_cipher_text,
    input  logic        core_enc_done,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESP} state_t;

    localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       rr_ptr;
    logic       owner;
    logic       grant_vld;
    logic       grant_id;
    logic       rsp_hs;
    logic       timed_out;
    logic [5:0] to_cnt;

    // Arbitration: the pointer only matters when both requesters are valid.
    // Ready is masked during reset so no job is consumed while the block is held.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE && !reset) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = rr_ptr;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready     = grant_vld && !grant_id;
    assign req1_ready     = grant_vld && grant_id;
    assign rsp0_valid     = (state == RESP) && !owner;
    assign rsp1_valid     = (state == RESP) && owner;
    assign rsp_hs         = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
    // The core only latches operands while its reset is high, so LOAD doubles as the load strobe.
    assign core_reset     = reset || (state == LOAD);
    assign core_enc_start = (state == START);
    assign busy           = (state != IDLE);
    assign timed_out      = (to_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = LOAD;
            LOAD:    state_nxt = START;
            START:   state_nxt = WAIT;
            // done is only trusted here; elsewhere it may be X or stale.
            WAIT:    if (core_enc_done || timed_out) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            rr_ptr          <= 1'b0;
            owner           <= 1'b0;
            to_cnt          <= 6'd0;
            core_plain_text <= 64'd0;
            core_master_key <= 80'd0;
            rsp0_cipher     <= 64'd0;
            rsp0_err        <= 1'b0;
            rsp1_cipher     <= 64'd0;
            rsp1_err        <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner           <= grant_id;
                        rr_ptr          <= ~grant_id;
                        core_plain_text <= grant_id ? req1_plain : req0_plain;
                        core_master_key <= grant_id ? req1_key : req0_key;
                    end
                end
                START: to_cnt <= 6'd0;
                WAIT: begin
                    // done wins over a coincident timeout.
                    if (core_enc_done) begin
                        if (owner) begin
                            rsp1_cipher <= core_cipher_text;
                            rsp1_err    <= 1'b0;
                        end else begin
                            rsp0_cipher <= core_cipher_text;
                            rsp0_err    <= 1'b0;
                        end
                    end else if (timed_out) begin
                        if (owner) begin
                            rsp1_cipher <= 64'd0;
                            rsp1_err    <= 1'b1;
                        end else begin
                            rsp0_cipher <= 64'd0;
                            rsp0_err    <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 6'd1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        if (owner) rsp1_err <= 1'b0;
                        else       rsp0_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boron_enc_scheduler.sv
// Directed bench for boron_enc_scheduler with a behavioural 25-round core model.
// Covers single job latency, round-robin contention, response backpressure,
// timeout, reset mid-job and stale core_enc_done outside WAIT.
module tb_boron_enc_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
    logic [63:0] req0_plain, req1_plain, rsp0_cipher, rsp1_cipher;
    logic [79:0] req0_key, req1_key;
    logic        core_reset, core_enc_start, core_enc_done, busy;
    logic [63:0] core_plain_text, core_cipher_text;
    logic [79:0] core_master_key;

    always #5 clk = ~clk;

    boron_enc_scheduler #(.TIMEOUT(40)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_plain(req0_plain), .req0_key(req0_key),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_cipher(rsp0_cipher), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_plain(req1_plain), .req1_key(req1_key),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_cipher(rsp1_cipher), .rsp1_err(rsp1_err),
        .core_reset(core_reset), .core_plain_text(core_plain_text), .core_master_key(core_master_key),
        .core_enc_start(core_enc_start), .core_cipher_text(core_cipher_text),
        .core_enc_done(core_enc_done), .busy(busy)
    );

    // Stand-in cipher function; the core model and the expectations both use it.
    function automatic logic [63:0] golden(input logic [63:0] p, input logic [79:0] k);
        return {p[31:0], p[63:32]} ^ k[79:16] ^ {48'h0, k[15:0]} ^ 64'h5A5A_0F0F_3C3C_9696;
    endfunction

    // Core model: latches operands while core_reset is high; start seen at the
    // end of cycle 2 puts it in cycle 3, done pulses in cycle 29.
    logic [63:0] m_plain;
    logic [79:0] m_key;
    logic        m_run;
    int          m_cnt;
    logic        never_done, force_done, model_done;

    always @(posedge clk) begin
        if (core_reset) begin
            m_plain <= core_plain_text;
            m_key   <= core_master_key;
            m_run   <= 1'b0;
            m_cnt   <= 0;
        end else if (core_enc_start) begin
            m_run <= 1'b1;
            m_cnt <= 3;
        end else if (m_run) begin
            if (m_cnt == 29) m_run <= 1'b0;
            else             m_cnt <= m_cnt + 1;
        end
    end

    assign model_done       = m_run && (m_cnt == 29) && !never_done;
    assign core_enc_done    = force_done || model_done;
    assign core_cipher_text = model_done ? golden(m_plain, m_key) : 64'hDEAD_BEEF_DEAD_BEEF;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Waits (bounded) for any rsp_valid; returns cycles since acceptance start.
    task automatic wait_rsp(input int start, output int lat);
        for (int i = 0; i < 200 && !(rsp0_valid || rsp1_valid); i++) tick();
        lat = cyc - start;
    endtask

    localparam logic [63:0] P0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] P1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [79:0] K1 = 80'h1111_2222_3333_4444_5555;
    localparam logic [63:0] P2 = 64'hCAFE_F00D_0BAD_BEEF;
    localparam logic [79:0] K2 = 80'h0F0F_0F0F_0F0F_0F0F_0F0F;

    initial begin
        int acc, lat, bad;
        logic own;
        logic [63:0] c0;

        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_plain = '0; req1_plain = '0; req0_key = '0; req1_key = '0;
        never_done = 0; force_done = 0;
        tick(); tick();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_start", core_enc_start, 0);
        check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("rst_cipher", rsp0_cipher | rsp1_cipher, 0);
        check("rst_operands", core_plain_text | core_master_key, 0);

        // Single job on requester 0
        reset = 0;
        req0_valid = 1; req0_plain = P0; req0_key = 80'h0;
        #1;
        check("single_ready", {req1_ready, req0_ready}, 2'b01);
        acc = cyc;
        tick();
        req0_valid = 0;
        check("single_load_core_reset", core_reset, 1);
        check("single_load_ready", req0_ready, 0);
        check("single_load_plain", core_plain_text, P0);
        tick();
        check("single_start", {core_reset, core_enc_start}, 2'b01);
        tick();
        check("single_start_pulse", core_enc_start, 0);
        wait_rsp(acc, lat);
        check("single_latency", lat, 30);
        check("single_cipher", rsp0_cipher, golden(P0, 80'h0));
        check("single_err", rsp0_err, 0);
        check("single_other_valid", rsp1_valid, 0);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        check("single_busy_after", {busy, rsp0_valid}, 0);

        // Contention from reset, with backpressure on the second job
        reset = 1;
        req0_valid = 1; req1_valid = 1;
        req0_plain = P1; req0_key = K1; req1_plain = P2; req1_key = K2;
        tick(); tick();
        check("cont_reset_ready", {req1_ready, req0_ready}, 0);
        reset = 0;
        #1;
        for (int j = 0; j < 4; j++) begin
            own = (j % 2 == 1);
            check($sformatf("cont_grant%0d", j), {req1_ready, req0_ready}, own ? 2'b10 : 2'b01);
            acc = cyc;
            tick();
            wait_rsp(acc, lat);
            check($sformatf("cont_lat%0d", j), lat, 30);
            check($sformatf("cont_route%0d", j), {rsp1_valid, rsp0_valid}, own ? 2'b10 : 2'b01);
            check($sformatf("cont_cipher%0d", j), own ? rsp1_cipher : rsp0_cipher,
                  own ? golden(P2, K2) : golden(P1, K1));
            if (j == 1) begin
                bad = 0;
                c0 = rsp1_cipher;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    if (!rsp1_valid || rsp1_cipher !== c0 || rsp1_err || req0_ready || req1_ready || rsp0_valid)
                        bad++;
                end
                check("bp_hold", bad, 0);
            end
            rsp0_ready = 1; rsp1_ready = 1;
            tick();
            rsp0_ready = 0; rsp1_ready = 0;
            #1;
        end
        req0_valid = 0; req1_valid = 0;
        #1;

        // Timeout: core never signals done
        never_done = 1;
        req0_valid = 1; req0_plain = P0; req0_key = K1;
        #1;
        acc = cyc;
        tick();
        req0_valid = 0;
        wait_rsp(acc, lat);
        check("to_latency", lat, 43);
        check("to_err", rsp0_err, 1);
        check("to_cipher", rsp0_cipher, 0);
        check("to_valid", {rsp1_valid, rsp0_valid}, 2'b01);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        check("to_after", {busy, rsp0_valid, rsp0_err}, 0);
        never_done = 0;

        // Reset during WAIT cycle 10 (cycle 12 after acceptance)
        req1_valid = 1; req1_plain = P0; req1_key = K2;
        #1;
        check("rmid_grant", {req1_ready, req0_ready}, 2'b10);
        acc = cyc;
        tick();
        req1_valid = 0;
        for (int i = 0; i < 11; i++) tick();
        check("rmid_in_wait", {busy, core_reset, core_enc_start}, 3'b100);
        reset = 1;
        #1;
        check("rmid_core_reset_comb", core_reset, 1);
        tick();
        check("rmid_state", {busy, rsp1_valid, rsp1_err, core_enc_start, core_reset}, 5'b00001);
        check("rmid_cipher", rsp1_cipher, 0);
        check("rmid_operands", core_plain_text | core_master_key, 0);
        reset = 0;
        tick();
        check("rmid_release", core_reset, 0);
        req1_valid = 1; req1_plain = P1; req1_key = K1;
        #1;
        acc = cyc;
        tick();
        req1_valid = 0;
        wait_rsp(acc, lat);
        check("rmid_job_lat", lat, 30);
        check("rmid_job_cipher", rsp1_cipher, golden(P1, K1));
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;

        // Stale done high through IDLE/LOAD/START must be ignored
        force_done = 1;
        tick();
        check("stale_idle", {busy, rsp0_valid}, 0);
        req0_valid = 1; req0_plain = P2; req0_key = K2;
        #1;
        acc = cyc;
        tick();
        req0_valid = 0;
        check("stale_load", {core_reset, rsp0_valid}, 2'b10);
        tick();
        check("stale_start", {core_enc_start, rsp0_valid}, 2'b10);
        force_done = 0;
        tick();
        check("stale_wait", {busy, rsp0_valid}, 2'b10);
        wait_rsp(acc, lat);
        check("stale_lat", lat, 30);
        check("stale_cipher", rsp0_cipher, golden(P2, K2));
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        check("stale_done_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
